// File: rtl/fifo_arb_pkg.sv
// Shared state encoding and sizing helpers for the FIFO write-port arbiter.
// The optional stats block in fifo_wr_arbiter is enabled by FIFO_ARB_STATS_EN.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int STAT_W = 16;

    // Counter must be able to hold MAXBEATS itself, hence the extra bit.
    function automatic int beat_cnt_w(input int maxbeats);
        return $clog2(maxbeats) + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotate-priority selector: first requester above last_owner, wrapping around.
// Purely combinational; one-hot gnt with a matching valid flag.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last_owner,
    output logic [NREQ-1:0]         gnt,
    output logic                    valid
);

    always_comb begin
        int idx;
        idx   = 0;
        gnt   = '0;
        valid = 1'b0;
        // Offset NREQ wraps to last_owner itself, so a lone requester can win again.
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_owner) + k) % NREQ;
            if (!valid && req[idx]) begin
                gnt[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin packet arbiter in front of an async FIFO write port (wclk domain).
// Define FIFO_ARB_STATS_EN to add per-requester packet counters (stat_sel/stat_cnt).
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DSIZE    = 8,
    parameter int MAXBEATS = 16
) (
    input  logic                    wclk,
    input  logic                    wrst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DSIZE-1:0]   req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    wfull,
    output logic                    winc,
    output logic [DSIZE-1:0]        wdata,
    output logic [NREQ-1:0]         grant,
    output logic                    trunc
`ifdef FIFO_ARB_STATS_EN
    ,
    input  logic [$clog2(NREQ)-1:0] stat_sel,
    output logic [STAT_W-1:0]       stat_cnt
`endif
);

    localparam int            LW      = $clog2(NREQ);
    localparam int            CW      = beat_cnt_w(MAXBEATS);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAXBEATS);

    arb_state_e      state;
    logic [LW-1:0]   last_owner;
    logic [LW-1:0]   owner;
    logic [CW-1:0]   beat_cnt;
    logic [NREQ-1:0] pick;
    logic            pick_vld;
    logic            own_last;
    logic            xfer;
    logic            at_max;
    logic            release_grant;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req        (req_valid),
        .last_owner (last_owner),
        .gnt        (pick),
        .valid      (pick_vld)
    );

    // grant is one-hot, so the last matching index is the only one.
    always_comb begin
        owner    = '0;
        wdata    = '0;
        own_last = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                owner    = LW'(i);
                wdata    = req_data[i*DSIZE +: DSIZE];
                own_last = req_last[i];
            end
        end
    end

    // Ready is gated by reset too, so a reset mid-packet leaves no trailing write.
    assign req_ready     = (state == BURST && !wfull && !wrst) ? grant : '0;
    assign xfer          = |(req_ready & req_valid);
    assign winc          = xfer;
    assign at_max        = (beat_cnt + CW'(1)) == CNT_MAX;
    assign release_grant = xfer && (own_last || at_max);

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state      <= IDLE;
            grant      <= '0;
            last_owner <= LW'(NREQ - 1);
            beat_cnt   <= '0;
            trunc      <= 1'b0;
        end else begin
            trunc <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant    <= pick;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (xfer) begin
                        beat_cnt <= beat_cnt + CW'(1);
                    end
                    if (release_grant) begin
                        trunc      <= !own_last;
                        state      <= IDLE;
                        grant      <= '0;
                        last_owner <= owner;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [NREQ-1:0][STAT_W-1:0] pkt_cnt;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            pkt_cnt  <= '0;
            stat_cnt <= '0;
        end else begin
            if (release_grant && pkt_cnt[owner] != '1) begin
                pkt_cnt[owner] <= pkt_cnt[owner] + STAT_W'(1);
            end
            stat_cnt <= (int'(stat_sel) < NREQ) ? pkt_cnt[stat_sel] : '0;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NREQ=4, DSIZE=8, MAXBEATS=16).
// Stats checks are compiled in only when FIFO_ARB_STATS_EN is defined.
module tb_fifo_wr_arbiter;

    logic        wclk = 1'b0;
    logic        wrst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        wfull;
    logic        winc;
    logic [7:0]  wdata;
    logic [3:0]  grant;
    logic        trunc;
`ifdef FIFO_ARB_STATS_EN
    logic [1:0]  stat_sel;
    logic [15:0] stat_cnt;
`endif

    always #5 wclk = ~wclk;

    fifo_wr_arbiter #(.NREQ(4), .DSIZE(8), .MAXBEATS(16)) dut (
        .wclk      (wclk),
        .wrst      (wrst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .grant     (grant),
        .trunc     (trunc)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stat_sel  (stat_sel),
        .stat_cnt  (stat_cnt)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    // per-requester packet sources
    logic [7:0] src_data [4][32];
    logic       src_last [4][32];
    int         src_len  [4];
    int         src_ptr  [4];
    logic [3:0] fire;

    // observations taken at the falling edge
    logic [3:0] obs_grant, obs_ready, prev_g;
    logic       obs_winc, obs_trunc;
    logic [7:0] obs_wdata;
    logic [7:0] log_d[$];
    int         log_o[$];
    int         gnt_seq[$];
    int         n_trunc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int oh2i(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic clear_src();
        for (int i = 0; i < 4; i++) begin
            src_len[i] = 0;
            src_ptr[i] = 0;
        end
        fire = '0;
    endtask

    task automatic clear_log();
        log_d.delete();
        log_o.delete();
        gnt_seq.delete();
        n_trunc = 0;
    endtask

    task automatic add_pkt(input int r, input int base, input int n);
        for (int k = 0; k < n; k++) begin
            src_data[r][src_len[r]] = 8'(base + k);
            src_last[r][src_len[r]] = (k == n - 1);
            src_len[r]++;
        end
    endtask

    task automatic drive_src();
        for (int i = 0; i < 4; i++) begin
            if (src_ptr[i] < src_len[i]) begin
                req_valid[i]        = 1'b1;
                req_data[i*8 +: 8]  = src_data[i][src_ptr[i]];
                req_last[i]         = src_last[i][src_ptr[i]];
            end else begin
                req_valid[i]        = 1'b0;
                req_data[i*8 +: 8]  = 8'h00;
                req_last[i]         = 1'b0;
            end
        end
    endtask

    task automatic tick(input logic f, input logic r);
        @(posedge wclk);
        #1;
        for (int i = 0; i < 4; i++) if (fire[i]) src_ptr[i]++;
        wfull = f;
        wrst  = r;
        drive_src();
        @(negedge wclk);
        obs_grant = grant;
        obs_ready = req_ready;
        obs_winc  = winc;
        obs_wdata = wdata;
        obs_trunc = trunc;
        fire      = req_valid & req_ready;
        if (winc) begin
            log_d.push_back(wdata);
            log_o.push_back(oh2i(grant));
        end
        if (grant != 4'b0 && prev_g == 4'b0) gnt_seq.push_back(oh2i(grant));
        prev_g = grant;
        if (trunc) n_trunc++;
    endtask

    task automatic chk_log(input string t, input int idx, input int own, input int d);
        chk($sformatf("%s_have%0d", t, idx), 32'(idx < log_d.size()), 32'd1);
        if (idx < log_d.size()) begin
            chk($sformatf("%s_d%0d", t, idx), 32'(log_d[idx]), 32'(d));
            chk($sformatf("%s_o%0d", t, idx), 32'(log_o[idx]), 32'(own));
        end
    endtask

    task automatic do_reset();
        clear_src();
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
    endtask

    initial begin
        int idx;
        int trunc_at;
        wrst = 1'b1;
        wfull = 1'b0;
        prev_g = '0;
        clear_src();
        clear_log();
        drive_src();
`ifdef FIFO_ARB_STATS_EN
        stat_sel = 2'd0;
`endif

        // reset with every requester valid: nothing may be accepted
        for (int i = 0; i < 4; i++) add_pkt(i, 8'h70 + i, 1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        chk("rst_winc", 32'(obs_winc), 32'd0);
        chk("rst_ready", 32'(obs_ready), 32'd0);
        chk("rst_grant", 32'(obs_grant), 32'd0);
        chk("rst_trunc", 32'(obs_trunc), 32'd0);
        clear_src();
        tick(1'b0, 1'b0);
        chk("idle_grant", 32'(obs_grant), 32'd0);
        chk("idle_winc", 32'(obs_winc), 32'd0);

        // single requester, 3-beat packet
        clear_log();
        add_pkt(0, 8'hA1, 3);
        tick(1'b0, 1'b0);
        chk("t2_c0_grant", 32'(obs_grant), 32'd0);
        chk("t2_c0_winc", 32'(obs_winc), 32'd0);
        tick(1'b0, 1'b0);
        chk("t2_c1_grant", 32'(obs_grant), 32'h1);
        chk("t2_c1_winc", 32'(obs_winc), 32'd1);
        chk("t2_c1_wdata", 32'(obs_wdata), 32'hA1);
        chk("t2_c1_ready", 32'(obs_ready), 32'h1);
        tick(1'b0, 1'b0);
        chk("t2_c2_winc", 32'(obs_winc), 32'd1);
        chk("t2_c2_wdata", 32'(obs_wdata), 32'hA2);
        tick(1'b0, 1'b0);
        chk("t2_c3_winc", 32'(obs_winc), 32'd1);
        chk("t2_c3_wdata", 32'(obs_wdata), 32'hA3);
        tick(1'b0, 1'b0);
        chk("t2_c4_grant", 32'(obs_grant), 32'd0);
        chk("t2_c4_winc", 32'(obs_winc), 32'd0);
        chk("t2_len", 32'(log_d.size()), 32'd3);

        // all four continuously valid, two 2-beat packets each
        do_reset();
        clear_log();
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 4; i++) add_pkt(i, 8'h10 * (i + 1) + p * 2, 2);
        for (int c = 0; c < 28; c++) tick(1'b0, 1'b0);
        chk("t3_ngrants", 32'(gnt_seq.size()), 32'd8);
        for (int g = 0; g < 8 && g < gnt_seq.size(); g++)
            chk($sformatf("t3_order%0d", g), 32'(gnt_seq[g]), 32'(g % 4));
        chk("t3_len", 32'(log_d.size()), 32'd16);
        idx = 0;
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 4; i++)
                for (int b = 0; b < 2; b++) begin
                    chk_log("t3", idx, i, 8'h10 * (i + 1) + p * 2 + b);
                    idx++;
                end

        // wfull held for three cycles in the middle of requester 2's packet
        clear_log();
        add_pkt(2, 8'hC0, 4);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("t4_grant", 32'(obs_grant), 32'h4);
        chk("t4_b0", 32'(obs_wdata), 32'hC0);
        tick(1'b0, 1'b0);
        chk("t4_b1", 32'(obs_wdata), 32'hC1);
        for (int c = 0; c < 3; c++) begin
            tick(1'b1, 1'b0);
            chk($sformatf("t4_full_winc%0d", c), 32'(obs_winc), 32'd0);
            chk($sformatf("t4_full_ready%0d", c), 32'(obs_ready), 32'd0);
            chk($sformatf("t4_full_grant%0d", c), 32'(obs_grant), 32'h4);
        end
        tick(1'b0, 1'b0);
        chk("t4_resume_winc", 32'(obs_winc), 32'd1);
        chk("t4_resume_wdata", 32'(obs_wdata), 32'hC2);
        tick(1'b0, 1'b0);
        chk("t4_b3", 32'(obs_wdata), 32'hC3);
        tick(1'b0, 1'b0);
        chk("t4_end_grant", 32'(obs_grant), 32'd0);
        chk("t4_len", 32'(log_d.size()), 32'd4);
        for (int k = 0; k < 4; k++) chk_log("t4", k, 2, 8'hC0 + k);

        // 20-beat packet on requester 0 with requester 1 waiting
        clear_log();
        add_pkt(0, 8'h40, 20);
        add_pkt(1, 8'h90, 1);
        trunc_at = -1;
        for (int c = 1; c <= 26; c++) begin
            tick(1'b0, 1'b0);
            if (obs_trunc && trunc_at < 0) trunc_at = c;
        end
        // 16th transfer is in cycle 17; the registered pulse follows in cycle 18
        chk("t5_trunc_cnt", 32'(n_trunc), 32'd1);
        chk("t5_trunc_at", 32'(trunc_at), 32'd18);
        chk("t5_ngrants", 32'(gnt_seq.size()), 32'd3);
        if (gnt_seq.size() == 3) begin
            chk("t5_g0", 32'(gnt_seq[0]), 32'd0);
            chk("t5_g1", 32'(gnt_seq[1]), 32'd1);
            chk("t5_g2", 32'(gnt_seq[2]), 32'd0);
        end
        chk("t5_len", 32'(log_d.size()), 32'd21);
        for (int k = 0; k < 16; k++) chk_log("t5", k, 0, 8'h40 + k);
        chk_log("t5", 16, 1, 8'h90);
        for (int k = 0; k < 4; k++) chk_log("t5", 17 + k, 0, 8'h50 + k);

        // reset in the middle of requester 1's packet
        clear_src();
        clear_log();
        add_pkt(1, 8'hE0, 4);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("t6_grant", 32'(obs_grant), 32'h2);
        tick(1'b0, 1'b0);
        chk("t6_b1", 32'(obs_wdata), 32'hE1);
        tick(1'b0, 1'b1);
        chk("t6_rst_winc", 32'(obs_winc), 32'd0);
        chk("t6_rst_ready", 32'(obs_ready), 32'd0);
        add_pkt(0, 8'h0F, 1);
        add_pkt(2, 8'h2F, 1);
        tick(1'b0, 1'b0);
        chk("t6_after_grant", 32'(obs_grant), 32'd0);
        chk("t6_after_winc", 32'(obs_winc), 32'd0);
        tick(1'b0, 1'b0);
        chk("t6_restart_grant", 32'(obs_grant), 32'h1);
        chk("t6_restart_wdata", 32'(obs_wdata), 32'h0F);
        chk("t6_len", 32'(log_d.size()), 32'd3);
        chk_log("t6", 0, 1, 8'hE0);
        chk_log("t6", 1, 1, 8'hE1);
        chk_log("t6", 2, 0, 8'h0F);

`ifdef FIFO_ARB_STATS_EN
        do_reset();
        for (int p = 0; p < 5; p++) add_pkt(3, 8'h30 + p, 1);
        for (int c = 0; c < 14; c++) tick(1'b0, 1'b0);
        stat_sel = 2'd3;
        tick(1'b0, 1'b0);
        chk("st_cnt3", 32'(stat_cnt), 32'd5);
        for (int s = 0; s < 3; s++) begin
            stat_sel = 2'(s);
            tick(1'b0, 1'b0);
            chk($sformatf("st_cnt%0d", s), 32'(stat_cnt), 32'd0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
